// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - shared speed encodings, state type and clock-pattern helper for the RGMII TX path
package rgmii_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FRAME   = 2'd1,
    ST_IFG     = 2'd2,
    ST_DISCARD = 2'd3
  } tx_state_t;

  // 2'b11 is an unused encoding; fold it onto gigabit so the rest of the logic sees three speeds.
  function automatic logic [1:0] norm_speed(input logic [1:0] s);
    return (s == 2'b11) ? SPEED_1000 : s;
  endfunction

  // {rise, fall} clock values for one cycle of a slow-speed slot. The slot holds two clock
  // periods of div cycles; the clock is high for the first div half-cycles of each period.
  function automatic logic [1:0] clk_pattern(input int phase, input int div);
    int k;
    k = (phase < div) ? phase : phase - div;
    return {(2 * k < div), (2 * k + 1 < div)};
  endfunction

endpackage

// File: rtl/rgmii_oddr_bank.sv
// rtl/rgmii_oddr_bank.sv - six same-edge output DDR cells (4 data, control, clock) for RGMII TX
module rgmii_oddr_bank
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] txd_d1,
  input  logic [3:0] txd_d2,
  input  logic       ctl_d1,
  input  logic       ctl_d2,
  input  logic       clk_d1,
  input  logic       clk_d2,
  output logic [3:0] rgmii_txd,
  output logic       rgmii_tx_ctl,
  output logic       rgmii_txc
);

  logic [5:0] rise_q;
  logic [5:0] fall_q;

  // Both halves are captured on the rising edge; the falling-edge half is driven while clk is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= {txd_d1, ctl_d1, clk_d1};
      fall_q <= {txd_d2, ctl_d2, clk_d2};
    end
  end

  assign {rgmii_txd, rgmii_tx_ctl, rgmii_txc} = clk ? rise_q : fall_q;

endmodule

// File: rtl/rgmii_tx_speed_adapter.sv
// rtl/rgmii_tx_speed_adapter.sv - tri-speed GMII to RGMII TX adapter producing per-edge DDR values
module rgmii_tx_speed_adapter
  import rgmii_pkg::*;
#(
  parameter int DIV_100   = 5,
  parameter int DIV_10    = 50,
  parameter int IFG_BYTES = 12
)
(
  input  logic       gmii_tx_clk,
  input  logic       reset_n,
  input  logic [1:0] speed,
  input  logic [7:0] s_txd,
  input  logic       s_txen,
  input  logic       s_txer,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [3:0] txd_d1,
  output logic [3:0] txd_d2,
  output logic       ctl_d1,
  output logic       ctl_d2,
  output logic       clk_d1,
  output logic       clk_d2,
  output logic       underrun,
  input  logic       underrun_clr
);

  localparam int PW = $clog2(2 * DIV_10);
  localparam int CW = $clog2(IFG_BYTES + 1);

  tx_state_t     state_q, state_d;
  logic [1:0]    speed_q, speed_d;
  logic [PW-1:0] phase_q, phase_d, slot_last;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          discard_q, discard_d;
  logic          underrun_q, underrun_d;
  logic          init_q;
  logic [7:0]    byte_q, byte_d;
  logic          en_q, en_d;
  logic          er_q, er_d;
  logic          slot_end, xfer;
  logic [3:0]    txd1_d, txd2_d, nib;
  logic          ctl1_d, ctl2_d, clk1_d, clk2_d;
  logic [1:0]    ck;
  int            div_sel;

  // Last phase value of a byte slot at the current speed.
  always_comb begin
    case (speed_q)
      SPEED_100: slot_last = PW'(2 * DIV_100 - 1);
      SPEED_10:  slot_last = PW'(2 * DIV_10 - 1);
      default:   slot_last = '0;
    endcase
  end

  assign slot_end = (phase_q == slot_last);
  assign s_ready  = init_q && slot_end && (state_q != ST_IFG);
  assign xfer     = s_valid && s_ready;
  assign underrun = underrun_q;

  // Frame state machine; the slot's byte is chosen at slot_end and held for the whole slot.
  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    phase_d    = slot_end ? '0 : phase_q + PW'(1);
    cnt_d      = cnt_q;
    discard_d  = discard_q;
    underrun_d = underrun_clr ? 1'b0 : underrun_q;
    byte_d     = byte_q;
    en_d       = en_q;
    er_d       = er_q;
    if (!init_q) begin
      speed_d = norm_speed(speed);
      phase_d = '0;
      state_d = ST_IDLE;
      byte_d  = '0;
      en_d    = 1'b0;
      er_d    = 1'b0;
    end else if (slot_end) begin
      byte_d = '0;
      en_d   = 1'b0;
      er_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          speed_d = norm_speed(speed);
          if (xfer && s_txen) begin
            byte_d  = s_txd;
            en_d    = 1'b1;
            er_d    = s_txer;
            state_d = ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (!s_valid) begin
            // Source ran dry: one error slot, then a full gap and drop the rest of the frame.
            en_d       = 1'b1;
            er_d       = 1'b1;
            underrun_d = 1'b1;
            cnt_d      = CW'(IFG_BYTES);
            discard_d  = 1'b1;
            state_d    = ST_IFG;
          end else if (s_txen) begin
            byte_d = s_txd;
            en_d   = 1'b1;
            er_d   = s_txer;
          end else if (IFG_BYTES == 1) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = CW'(IFG_BYTES - 1);
            state_d = ST_IFG;
          end
        end
        ST_IFG: begin
          if (cnt_q <= CW'(1)) begin
            cnt_d     = '0;
            discard_d = 1'b0;
            state_d   = discard_q ? ST_DISCARD : ST_IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          if (xfer && !s_txen) state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Map the held byte and the next phase onto per-edge data, control and clock values.
  always_comb begin
    div_sel = (speed_d == SPEED_100) ? DIV_100 : DIV_10;
    ck      = clk_pattern(int'(phase_d), div_sel);
    nib     = (int'(phase_d) < div_sel) ? byte_d[3:0] : byte_d[7:4];
    if (speed_d == SPEED_1000) begin
      txd1_d = byte_d[3:0];
      txd2_d = byte_d[7:4];
      clk1_d = 1'b1;
      clk2_d = 1'b0;
    end else begin
      txd1_d = nib;
      txd2_d = nib;
      clk1_d = ck[1];
      clk2_d = ck[0];
    end
    ctl1_d = en_d;
    ctl2_d = en_d ^ er_d;
  end

  // State and output registers; reset clears everything and holds the clock low.
  always_ff @(posedge gmii_tx_clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      speed_q    <= SPEED_10;
      phase_q    <= '0;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
      underrun_q <= 1'b0;
      init_q     <= 1'b0;
      byte_q     <= '0;
      en_q       <= 1'b0;
      er_q       <= 1'b0;
      txd_d1     <= '0;
      txd_d2     <= '0;
      ctl_d1     <= 1'b0;
      ctl_d2     <= 1'b0;
      clk_d1     <= 1'b0;
      clk_d2     <= 1'b0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      discard_q  <= discard_d;
      underrun_q <= underrun_d;
      init_q     <= 1'b1;
      byte_q     <= byte_d;
      en_q       <= en_d;
      er_q       <= er_d;
      txd_d1     <= txd1_d;
      txd_d2     <= txd2_d;
      ctl_d1     <= ctl1_d;
      ctl_d2     <= ctl2_d;
      clk_d1     <= clk1_d;
      clk_d2     <= clk2_d;
    end
  end

endmodule
